load_store_unit: RTL

//  Multi-cycle data-memory stage directly downstream of the ALU in the RISC-V datapath.

---
 rtl/load_store_unit.sv | 122 ++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - multi-cycle byte/half/word load-store stage with stall handshake
// Word-organised RAM; requests are latched at acceptance and complete after LATENCY stall cycles.
module load_store_unit #(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        memRead_i,
   input  logic        memWrite_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] address_i,
   input  logic [31:0] writeData_i,
   output logic [31:0] readData_o,
   output logic        stall_o,
   output logic        fault_o
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   state_t         state_q;
   logic [3:0]     cnt_q;
   logic [AW+1:0]  addr_q;
   logic [2:0]     f3_q;
   logic [31:0]    wd_q;
   logic           wr_q;
   logic [31:0]    mem_q [DEPTH];

   logic           req, legal_f3, misaligned, accept, fire, is_idle;
   logic [AW+1:0]  a_s;
   logic [2:0]     f3_s;
   logic [31:0]    wd_s, rd_word, load_val, wdata;
   logic           wr_s;
   logic [7:0]     byte_sel;
   logic [15:0]    half_sel;
   logic [3:0]     be;
   logic           unused_addr;

   assign unused_addr = ^address_i[31:AW+2];
   assign is_idle     = (state_q == S_IDLE);
   assign req         = memRead_i | memWrite_i;
   assign legal_f3    = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                        (funct3_i == 3'b100) || (funct3_i == 3'b101);
   assign misaligned  = ((funct3_i[1:0] == 2'b01) && address_i[0]) ||
                        ((funct3_i == 3'b010) && (address_i[1:0] != 2'b00));
   assign fault_o     = is_idle && req && ((memRead_i && memWrite_i) || !legal_f3 || misaligned ||
                        (memWrite_i && funct3_i[2]));
   assign accept      = is_idle && req && !fault_o;
   assign stall_o     = accept || (state_q == S_WAIT);
   assign fire        = (accept && (LATENCY == 1)) || ((state_q == S_WAIT) && (cnt_q == 4'd1));

   // With LATENCY=1 the completing edge is the accepting edge, so use live inputs in IDLE.
   assign a_s  = is_idle ? address_i[AW+1:0] : addr_q;
   assign f3_s = is_idle ? funct3_i : f3_q;
   assign wd_s = is_idle ? writeData_i : wd_q;
   assign wr_s = is_idle ? memWrite_i : wr_q;

   assign rd_word = mem_q[a_s[AW+1:2]];

   always_comb begin
      byte_sel = rd_word[7:0];
      case (a_s[1:0])
         2'd1:    byte_sel = rd_word[15:8];
         2'd2:    byte_sel = rd_word[23:16];
         2'd3:    byte_sel = rd_word[31:24];
         default: byte_sel = rd_word[7:0];
      endcase
      half_sel = a_s[1] ? rd_word[31:16] : rd_word[15:0];
      case (f3_s)
         3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
         3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
         3'b100:  load_val = {24'd0, byte_sel};
         3'b101:  load_val = {16'd0, half_sel};
         default: load_val = rd_word;
      endcase
      case (f3_s[1:0])
         2'b00:   begin be = 4'b0001 << a_s[1:0]; wdata = {4{wd_s[7:0]}};  end
         2'b01:   begin be = a_s[1] ? 4'b1100 : 4'b0011; wdata = {2{wd_s[15:0]}}; end
         default: begin be = 4'b1111; wdata = wd_s; end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= S_IDLE;
         cnt_q      <= 4'd0;
         readData_o <= 32'd0;
         addr_q     <= '0;
         f3_q       <= 3'd0;
         wd_q       <= 32'd0;
         wr_q       <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (accept) begin
               cnt_q   <= 4'(LATENCY - 1);
               addr_q  <= address_i[AW+1:0];
               f3_q    <= funct3_i;
               wd_q    <= writeData_i;
               wr_q    <= memWrite_i;
               state_q <= (LATENCY > 1) ? S_WAIT : S_DONE;
            end
            S_WAIT: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) state_q <= S_DONE;
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
         if (fire && !wr_s) readData_o <= load_val;
      end
   end

   // RAM is deliberately outside reset; a reset on the completing edge aborts the store.
   always_ff @(posedge clk_i) begin
      if (!reset_i && fire && wr_s) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem_q[a_s[AW+1:2]][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end
endmodule
